// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port, decoder-side
// valid/stall handshake and the PC redirect input from branch/writeback.
// The fetch unit connects through the master modport; the memory/decoder
// side (or a testbench) uses the slave modport.
interface fetch_if #(
  parameter int ADDR_W = 16
);
  // Instruction-memory read port
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_valid;
  logic [15:0]       imem_rdata;

  // Decoder handshake
  logic              stall;
  logic [15:0]       instruction;
  logic              instr_valid;
  logic [ADDR_W-1:0] instr_pc;

  // PC redirect from branch / writeback
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instruction, instr_valid, instr_pc,
    input  imem_valid, imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instruction, instr_valid, instr_pc,
    output imem_valid, imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the word-addressed PC, issues one registered
// read strobe at a time to instruction memory and holds the returned 16-bit
// instruction for the decoder until it is consumed (stall=0). A redirect
// loads a new PC, flushes the held instruction and, if a read is still in
// flight, parks in DRAIN until that stale word has come back and been dropped.
//
// Optional build macro FETCH_PERF_CNT_EN adds two saturating 16-bit
// performance counters (fetch_count, redirect_count) as extra output ports.
module fetch_unit #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [15:0]       NOP_INSTR = 16'hBF00
) (
  input  logic      clk,
  input  logic      reset,
  fetch_if.master   bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] fetch_count,
  output logic [15:0] redirect_count
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // issue a read at pc
    WAIT  = 2'd1,  // read outstanding, waiting for imem_valid
    HOLD  = 2'd2,  // instruction presented, waiting for stall=0
    DRAIN = 2'd3   // stale read outstanding, drop its data
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;

  // Next-state and next-output decode; redirect overrides every state action.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = 1'b0;          // the read strobe is a one-cycle pulse
    addr_d  = addr_q;
    instr_d = instr_q;
    valid_d = valid_q;
    ipc_d   = ipc_q;

    if (bus.redirect) begin
      pc_d    = bus.redirect_pc;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      unique case (state_q)
        // A read is in flight: wait for it unless its data arrives right now,
        // in which case it is simply discarded.
        WAIT, DRAIN: state_d = bus.imem_valid ? FETCH : DRAIN;
        default:     state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = WAIT;
        end
        WAIT: begin
          if (bus.imem_valid) begin
            instr_d = bus.imem_rdata;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 1'b1;
            state_d = HOLD;
          end
        end
        HOLD: begin
          // Consumed this cycle: issue the next read directly, no FETCH bubble.
          if (!bus.stall) begin
            req_d   = 1'b1;
            addr_d  = pc_q;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            state_d = WAIT;
          end
        end
        DRAIN: begin
          if (bus.imem_valid) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      ipc_q   <= ipc_d;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instruction = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr_pc    = ipc_q;

`ifdef FETCH_PERF_CNT_EN
  logic accept;

  assign accept = (state_q == HOLD) && !bus.stall && !bus.redirect;

  // Saturating counters of consumed instructions and redirect cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count    <= '0;
      redirect_count <= '0;
    end else begin
      if (accept && (fetch_count != 16'hFFFF))
        fetch_count <= fetch_count + 16'd1;
      if (bus.redirect && (redirect_count != 16'hFFFF))
        redirect_count <= redirect_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A driver applies directed and random
// stall/redirect stimulus and pushes the fetch address it expects next into a
// queue; an independent monitor pops that queue whenever a new instruction is
// presented and checks PC and data against a memory-content function. A
// variable-latency memory model answers the read strobes.
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'hBF00;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  fetch_if #(.ADDR_W(16)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
  logic [15:0] redirect_count;
`endif

  fetch_unit #(
    .ADDR_W   (16),
    .RESET_PC (16'h0000),
    .NOP_INSTR(16'hBF00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count),
    .redirect_count(redirect_count)
`endif
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_mis = 0;
  logic [15:0] exp_q[$];        // expected fetch addresses, in program order
  logic [15:0] next_pc = 16'h0; // address of the most recently expected fetch
  int          lat_mode = 1;    // 0: random 1..3 cycles, else fixed latency
  int          n_acc = 0;
  int          n_red = 0;

  // Memory contents: a few fixed words for the directed tests, hash elsewhere.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'd0:   return 16'h1888;
      16'd1:   return 16'h2005;
      16'd2:   return 16'h4008;
      16'd3:   return 16'h1234;
      default: return (a * 16'd40503) ^ 16'h5A3C;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Apply one cycle of decoder/redirect stimulus and advance the program model.
  task automatic drive(input logic st, input logic rd, input logic [15:0] rpc);
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    if (rd) begin
      exp_q.delete();
      exp_q.push_back(rpc);
      next_pc = rpc;
      n_red++;
    end else if (bus.instr_valid && !st) begin
      next_pc = next_pc + 16'd1;
      exp_q.push_back(next_pc);
      n_acc++;
    end
  endtask

  task automatic run_to(input logic [15:0] pc, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus.instr_valid && bus.instr_pc == pc) begin
        ok = 1'b1;
        return;
      end
      drive(1'b0, 1'b0, 16'h0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset        = 1'b1;
    bus.stall    = 1'b0;
    bus.redirect = 1'b0;
    #1;
    check("rst_instr_valid", bus.instr_valid, 1'b0);
    check("rst_instruction", bus.instruction, NOP);
    check("rst_imem_req", bus.imem_req, 1'b0);
    check("rst_imem_addr", bus.imem_addr, 16'h0);
    check("rst_instr_pc", bus.instr_pc, 16'h0);
    exp_q.delete();
    exp_q.push_back(16'h0);
    next_pc = 16'h0;
    n_acc   = 0;
    n_red   = 0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    step();
    check("post_rst_req", bus.imem_req, 1'b1);
    check("post_rst_addr", bus.imem_addr, 16'h0);
  endtask

  // Memory model: registers each strobe and answers after the chosen latency.
  initial begin : memory
    logic        pend;
    logic [15:0] paddr;
    int          cnt;
    pend           = 1'b0;
    paddr          = 16'h0;
    cnt            = 0;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend           = 1'b0;
        bus.imem_valid = 1'b0;
      end else begin
        bus.imem_valid = 1'b0;
        if (pend) begin
          if (cnt <= 1) begin
            bus.imem_valid = 1'b1;
            bus.imem_rdata = mem_word(paddr);
            pend           = 1'b0;
          end else begin
            cnt--;
          end
        end
        if (bus.imem_req) begin
          pend  = 1'b1;
          paddr = bus.imem_addr;
          cnt   = (lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode;
        end
      end
    end
  end

  // Monitor: compares each presented instruction and each read address.
  logic        mon_held = 1'b0;
  logic        mon_prev_req = 1'b0;
  logic [15:0] mon_pc = 16'h0;
  logic [15:0] mon_ins = 16'h0;
  int          mon_idle = 0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_held     = 1'b0;
        mon_prev_req = 1'b0;
        mon_idle     = 0;
      end else begin
        if (bus.instr_valid) begin
          mon_idle = 0;
          if (!mon_held) begin
            if (exp_q.size() == 0) begin
              n_vec++;
              n_mis++;
              $display("FAIL unexpected_instr: got pc %0h, expected no instruction", bus.instr_pc);
            end else begin
              mon_pc  = exp_q.pop_front();
              mon_ins = mem_word(mon_pc);
              check("instr_pc", bus.instr_pc, mon_pc);
              check("instruction", bus.instruction, mon_ins);
            end
            mon_held = 1'b1;
          end else begin
            check("held_pc", bus.instr_pc, mon_pc);
            check("held_instr", bus.instruction, mon_ins);
          end
          check("no_req_while_valid", bus.imem_req, 1'b0);
        end else begin
          mon_held = 1'b0;
          check("nop_when_idle", bus.instruction, NOP);
          if (bus.redirect) mon_idle = 0;
          else              mon_idle++;
          if (mon_idle > 40) begin
            n_vec++;
            n_mis++;
            $display("FAIL liveness: got %0d idle cycles, expected at most 40", mon_idle);
            mon_idle = 0;
          end
        end
        if (bus.imem_req) begin
          check("req_single_pulse", mon_prev_req, 1'b0);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL stray_req: got read at %0h, expected no read", bus.imem_addr);
          end else begin
            check("imem_addr", bus.imem_addr, exp_q[0]);
          end
        end
        mon_prev_req = bus.imem_req;
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL timeout: got no end of run, expected finish within 600000");
    $fatal(1, "bench timeout");
  end

  initial begin : driver
    logic ok;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0;
    exp_q.push_back(16'h0);
    lat_mode = 1;

    // Power-on reset, then the first read must target address 0.
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    step();
    check("first_req", bus.imem_req, 1'b1);
    check("first_addr", bus.imem_addr, 16'h0);
    drive(1'b0, 1'b0, 16'h0);

    // Straight-line fetch of addresses 0, 1, 2 with 1-cycle memory.
    run_to(16'd2, ok);
    check("reach_pc2", ok, 1'b1);
    drive(1'b0, 1'b0, 16'h0);

    // Back to address 1, stall 3 cycles on 16'h2005, then release.
    step();
    drive(1'b0, 1'b1, 16'd1);
    run_to(16'd1, ok);
    check("reach_pc1", ok, 1'b1);
    drive(1'b1, 1'b0, 16'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_instr", bus.instruction, 16'h2005);
      check("stall_no_req", bus.imem_req, 1'b0);
      drive((k < 2) ? 1'b1 : 1'b0, 1'b0, 16'h0);
    end
    step();
    check("release_req", bus.imem_req, 1'b1);
    check("release_addr", bus.imem_addr, 16'd2);
    drive(1'b0, 1'b0, 16'h0);

    // 3-cycle memory: redirect to 0x40 while the read of 16'h1234 is in flight.
    lat_mode = 3;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      step();
      if (bus.imem_req && bus.imem_addr == 16'd3) begin
        drive(1'b0, 1'b1, 16'h0040);
        ok = 1'b1;
      end else begin
        drive(1'b0, 1'b0, 16'h0);
      end
    end
    check("saw_req_addr3", ok, 1'b1);
    run_to(16'h0040, ok);
    check("reach_0040", ok, 1'b1);
    drive(1'b0, 1'b0, 16'h0);

    // PC wrap from 0xFFFF to 0x0000.
    lat_mode = 0;
    step();
    drive(1'b0, 1'b1, 16'hFFFF);
    run_to(16'hFFFF, ok);
    check("reach_ffff", ok, 1'b1);
    drive(1'b0, 1'b0, 16'h0);
    step();
    check("wrap_req", bus.imem_req, 1'b1);
    check("wrap_addr", bus.imem_addr, 16'h0000);
    drive(1'b0, 1'b0, 16'h0);
    run_to(16'h0000, ok);
    check("reach_0000", ok, 1'b1);
    drive(1'b0, 1'b0, 16'h0);

    // Random stall/redirect traffic with random memory latency and mid-run resets.
    for (int i = 0; i < 2400; i++) begin
      logic        st;
      logic        rd;
      logic [15:0] rpc;
      if (i == 800 || i == 1600) do_reset();
      step();
      st  = ($urandom_range(0, 99) < 35);
      rd  = ($urandom_range(0, 99) < 5);
      rpc = ($urandom_range(0, 3) == 0) ? (16'hFFFE + 16'($urandom_range(0, 1)))
                                        : 16'($urandom);
      drive(st, rd, rpc);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      drive(1'b0, 1'b0, 16'h0);
    end

`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", fetch_count, (n_acc > 65535) ? 65535 : n_acc);
    check("redirect_count", redirect_count, (n_red > 65535) ? 65535 : n_red);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
